// File: rtl/bat_amateur_sequencer_if.sv
// Sequencer <-> microcode ROM / control bundle. The master drives the ROM-side
// controls; the sequencer takes the slave view.
interface bat_amateur_sequencer_if #(
  parameter int UOP_W  = 3,
  parameter int NFLAGS = 2,
  parameter int CNT_W  = 16
);
  logic              STALL;
  logic              RESET_uOP;
  logic              READ_FLAGS;
  logic              HALT_REQ;
  logic              RESUME;
  logic [NFLAGS-1:0] FLAG_MASK;
  logic [NFLAGS-1:0] ALU_FLAGS;
  logic [UOP_W-1:0]  uOP;
  logic [NFLAGS-1:0] FLAGS;
  logic              HALTED;
  logic              FAULT;
  logic [CNT_W-1:0]  RETIRED;

  modport master (
    output STALL, RESET_uOP, READ_FLAGS, HALT_REQ, RESUME, FLAG_MASK, ALU_FLAGS,
    input  uOP, FLAGS, HALTED, FAULT, RETIRED
  );
  modport slave (
    input  STALL, RESET_uOP, READ_FLAGS, HALT_REQ, RESUME, FLAG_MASK, ALU_FLAGS,
    output uOP, FLAGS, HALTED, FAULT, RETIRED
  );
endinterface

// File: rtl/bat_amateur_sequencer.sv
// BatAmateur micro-step sequencer: step counter, masked flag latch, stall,
// step-overflow fault and retired counter. Halt/resume built only with BAT_SEQ_HALT_EN.
module bat_amateur_sequencer #(
  parameter int UOP_W    = 3,
  parameter int NFLAGS   = 2,
  parameter int MAX_STEP = 6,
  parameter int CNT_W    = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  bat_amateur_sequencer_if.slave  bus
);
  localparam logic [1:0] S_RUN = 2'd0;
`ifdef BAT_SEQ_HALT_EN
  localparam logic [1:0] S_HALT = 2'd1;
`endif
  localparam logic [1:0] S_FLT = 2'd2;

  localparam logic [UOP_W-1:0] RESET_STEP = '1;

  logic [1:0]        r_state;
  logic [UOP_W-1:0]  r_uop;
  logic [NFLAGS-1:0] r_flags;
  logic [CNT_W-1:0]  r_retired;

  logic              w_halt_req;
  logic              w_end;
  logic              w_ovf;
  logic [NFLAGS-1:0] w_flags_nxt;

`ifdef BAT_SEQ_HALT_EN
  assign w_halt_req = bus.HALT_REQ;
`else
  // Halt controls are dead inputs in this build.
  logic w_unused_halt;
  assign w_unused_halt = &{1'b0, bus.HALT_REQ, bus.RESUME};
  assign w_halt_req    = 1'b0;
`endif

  assign w_end       = bus.RESET_uOP | w_halt_req;
  assign w_ovf       = (r_uop == UOP_W'(MAX_STEP)) & ~w_end;
  assign w_flags_nxt = (r_flags & ~bus.FLAG_MASK) | (bus.ALU_FLAGS & bus.FLAG_MASK);

  // Falling-edge update lets the ROM settle before rising-edge datapath regs.
  always_ff @(negedge CLK) begin
    if (RST) begin
      r_state   <= S_RUN;
      r_uop     <= RESET_STEP;
      r_flags   <= '0;
      r_retired <= '0;
    end else if (r_state == S_FLT) begin
      r_state <= S_FLT;
`ifdef BAT_SEQ_HALT_EN
    end else if (r_state == S_HALT) begin
      if (bus.RESUME) r_state <= S_RUN;
`endif
    end else if (!bus.STALL) begin
      if (w_ovf) begin
        r_state <= S_FLT;
      end else begin
        if (bus.READ_FLAGS) r_flags <= w_flags_nxt;
        if (w_end) begin
          r_uop     <= RESET_STEP;
          r_retired <= r_retired + CNT_W'(1);
`ifdef BAT_SEQ_HALT_EN
          if (w_halt_req) r_state <= S_HALT;
`endif
        end else begin
          r_uop <= r_uop + UOP_W'(1);
        end
      end
    end
  end

  assign bus.uOP     = r_uop;
  assign bus.FLAGS   = r_flags;
  assign bus.FAULT   = (r_state == S_FLT);
  assign bus.RETIRED = r_retired;
`ifdef BAT_SEQ_HALT_EN
  assign bus.HALTED  = (r_state == S_HALT);
`else
  assign bus.HALTED  = 1'b0;
`endif
endmodule

// File: tb/tb_bat_amateur_sequencer.sv
// Scoreboard bench for bat_amateur_sequencer: expected outputs are queued when a
// cycle's stimulus is applied and checked after the falling edge that acts on it.
module tb_bat_amateur_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bat_amateur_sequencer_if #(.UOP_W(3), .NFLAGS(2), .CNT_W(16)) bus ();

  bat_amateur_sequencer #(.UOP_W(3), .NFLAGS(2), .MAX_STEP(6), .CNT_W(16)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  typedef struct {
    string       tag;
    logic [2:0]  u;
    logic [1:0]  f;
    logic        h;
    logic        flt;
    logic [15:0] ret;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One falling edge: drive inputs, queue expectation, then compare.
  task automatic cyc(input string tag, input logic r, st, rs, rf, hq, rm,
                     input logic [1:0] msk, alu,
                     input logic [2:0] eu, input logic [1:0] ef,
                     input logic eh, eflt, input logic [15:0] eret);
    exp_t e;
    rst = r; bus.STALL = st; bus.RESET_uOP = rs; bus.READ_FLAGS = rf;
    bus.HALT_REQ = hq; bus.RESUME = rm; bus.FLAG_MASK = msk; bus.ALU_FLAGS = alu;
    e.tag = tag; e.u = eu; e.f = ef; e.h = eh; e.flt = eflt; e.ret = eret;
    q.push_back(e);
    @(negedge clk);
    #1;
    if (q.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      chk({e.tag, ".uop"},     {29'd0, bus.uOP},     {29'd0, e.u});
      chk({e.tag, ".flags"},   {30'd0, bus.FLAGS},   {30'd0, e.f});
      chk({e.tag, ".halted"},  {31'd0, bus.HALTED},  {31'd0, e.h});
      chk({e.tag, ".fault"},   {31'd0, bus.FAULT},   {31'd0, e.flt});
      chk({e.tag, ".retired"}, {16'd0, bus.RETIRED}, {16'd0, e.ret});
    end
  endtask

  initial begin
    rst = 1'b1; bus.STALL = 0; bus.RESET_uOP = 0; bus.READ_FLAGS = 0;
    bus.HALT_REQ = 0; bus.RESUME = 0; bus.FLAG_MASK = 0; bus.ALU_FLAGS = 0;
    @(posedge clk);

    //        tag    rst st rs rf hq rm msk    alu    u  f      h flt ret
    cyc("rst",      1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 7, 2'b00, 0, 0, 16'd0);
    // free run with RESET_uOP at step 4
    cyc("run0",     0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 16'd0);
    cyc("run1",     0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 0, 0, 16'd0);
    cyc("run2",     0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2, 2'b00, 0, 0, 16'd0);
    cyc("run3",     0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3, 2'b00, 0, 0, 16'd0);
    cyc("run4",     0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4, 2'b00, 0, 0, 16'd0);
    cyc("rsuop",    0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 7, 2'b00, 0, 0, 16'd1);
    cyc("run0b",    0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 16'd1);
    cyc("run1b",    0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b00, 0, 0, 16'd1);
    cyc("run2b",    0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2, 2'b00, 0, 0, 16'd1);
    // stall at step 2 with READ_FLAGS: nothing moves
    for (int i = 0; i < 3; i++)
      cyc("stall",  0, 1, 0, 1, 0, 0, 2'b11, 2'b11, 2, 2'b00, 0, 0, 16'd1);
    cyc("unstall",  0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3, 2'b00, 0, 0, 16'd1);
    // masked flag capture
    cyc("flg_m01",  0, 0, 0, 1, 0, 0, 2'b01, 2'b11, 4, 2'b01, 0, 0, 16'd1);
    cyc("flg_m10",  0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 5, 2'b01, 0, 0, 16'd1);
    cyc("rsuop5",   0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 7, 2'b01, 0, 0, 16'd2);
    cyc("to0",      0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 0, 0, 16'd2);
    cyc("to1",      0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 2'b01, 0, 0, 16'd2);
    cyc("to2",      0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2, 2'b01, 0, 0, 16'd2);
    cyc("to3",      0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3, 2'b01, 0, 0, 16'd2);
`ifdef BAT_SEQ_HALT_EN
    cyc("halt",     0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 7, 2'b01, 1, 0, 16'd3);
    // all ROM controls ignored while halted
    for (int i = 0; i < 5; i++)
      cyc("halted", 0, i[0], i[1], 1, i[0], 0, 2'b11, 2'b10, 7, 2'b01, 1, 0, 16'd3);
    cyc("resume",   0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 7, 2'b01, 0, 0, 16'd3);
    cyc("post_res", 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 0, 0, 16'd3);
`else
    cyc("nohalt4",  0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4, 2'b01, 0, 0, 16'd2);
    cyc("nohalt5",  0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 5, 2'b01, 0, 0, 16'd2);
    cyc("nohalt6",  0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 6, 2'b01, 0, 0, 16'd2);
    cyc("nohalt_rs",0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 7, 2'b01, 0, 0, 16'd3);
    cyc("post_rs",  0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b01, 0, 0, 16'd3);
`endif
    // run through MAX_STEP to the overflow trap
    for (int i = 1; i <= 6; i++)
      cyc("climb",  0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'(i), 2'b01, 0, 0, 16'd3);
    cyc("ovf",      0, 0, 0, 1, 0, 0, 2'b11, 2'b10, 6, 2'b01, 0, 1, 16'd3);
    cyc("flt_res",  0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 6, 2'b01, 0, 1, 16'd3);
    cyc("flt_stl",  0, 1, 0, 1, 0, 0, 2'b11, 2'b10, 6, 2'b01, 0, 1, 16'd3);
    cyc("flt_rs",   0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 6, 2'b01, 0, 1, 16'd3);
    cyc("flt_rst",  1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 7, 2'b00, 0, 0, 16'd0);

    // retired wrap: RESET_uOP every cycle pumps the counter to 16'hFFFE
    rst = 1'b0; bus.RESET_uOP = 1'b1;
    for (int i = 0; i < 65534; i++) @(negedge clk);
    #1;
    cyc("ret_ffff", 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 7, 2'b00, 0, 0, 16'hFFFF);
    cyc("ret_wrap", 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 7, 2'b00, 0, 0, 16'h0000);
    cyc("w0",       0, 0, 0, 1, 0, 0, 2'b11, 2'b10, 0, 2'b10, 0, 0, 16'h0000);
    for (int i = 1; i <= 5; i++)
      cyc("w_climb",0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'(i), 2'b10, 0, 0, 16'h0000);
    cyc("rst_mid",  1, 0, 0, 1, 1, 0, 2'b11, 2'b11, 7, 2'b00, 0, 0, 16'h0000);
    cyc("after_rst",0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 2'b00, 0, 0, 16'h0000);

    if (q.size() != 0) chk("sb_leftover", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
